synth_key_decoder: RTL and testbench

SYNTH_KEY_DECODER -- requirements
Module: synth_key_decoder

---
 rtl/synth_key_if.sv | 25 ++
 rtl/synth_key_decoder.sv | 149 ++++++++++++++
 tb/tb_synth_key_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/synth_key_if.sv
// Scan-code input and decoded note/command outputs of the synth key decoder.
// slave = decoder side, master = driver/consumer side.
interface synth_key_if;
  logic [7:0] iScanCode;
  logic       iScanValid;
  logic [3:0] oNote;
  logic       oNoteIn;
  logic       oOctavePlusPlus;
  logic       oOctaveMinusMinus;
  logic       oADSRPlusPlus;
  logic       oADSRMinusMinus;
  logic [2:0] oADSRSelector;

  modport slave (
    input  iScanCode, iScanValid,
    output oNote, oNoteIn, oOctavePlusPlus, oOctaveMinusMinus,
           oADSRPlusPlus, oADSRMinusMinus, oADSRSelector
  );

  modport master (
    output iScanCode, iScanValid,
    input  oNote, oNoteIn, oOctavePlusPlus, oOctaveMinusMinus,
           oADSRPlusPlus, oADSRMinusMinus, oADSRSelector
  );
endinterface

// File: rtl/synth_key_decoder.sv
// PS/2 set-2 scan-code decoder for a keyboard synth: notes, octave/ADSR commands, ADSR stage select.
// Optional macro SYNTH_KEY_TYPEMATIC_FILTER_EN suppresses typematic repeats of held keys.
//
// state   | meaning
// IDLE    | waiting for make code or prefix
// BRK     | F0 seen, next byte is a break code
// EXT     | E0 seen, next byte is an extended key (ignored)
// EXT_BRK | E0 F0 seen, next byte is an extended break (ignored)
module synth_key_decoder (
  input logic        iClock,
  input logic        iReset,
  synth_key_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_make;
  logic       w_brk;

  logic       w_is_note;
  logic [3:0] w_note_idx;
  logic [3:0] w_ctl;
  logic       w_is_sel;
  logic [2:0] w_sel;

  logic [3:0] r_note;
  logic       r_note_in;
  logic [3:0] r_pulse;
  logic [2:0] r_sel;

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    if (bus.iScanValid) begin
      case (r_state)
        IDLE: begin
          if (bus.iScanCode == CODE_BRK)      w_state_nxt = BRK;
          else if (bus.iScanCode == CODE_EXT) w_state_nxt = EXT;
          else                                w_make = 1'b1;
        end
        BRK: begin
          // A repeated F0 is tolerated; E0 here means a broken stream and is dropped.
          if (bus.iScanCode != CODE_BRK) begin
            w_state_nxt = IDLE;
            w_brk       = (bus.iScanCode != CODE_EXT);
          end
        end
        EXT: begin
          if (bus.iScanCode == CODE_BRK) w_state_nxt = EXT_BRK;
          else                           w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Pulse bit order: {octave++, octave--, adsr++, adsr--}
  always_comb begin
    w_is_note  = 1'b1;
    w_note_idx = 4'd0;
    w_ctl      = 4'b0000;
    w_is_sel   = 1'b0;
    w_sel      = 3'd0;
    case (bus.iScanCode)
      8'h1A: w_note_idx = 4'd0;
      8'h1B: w_note_idx = 4'd1;
      8'h22: w_note_idx = 4'd2;
      8'h23: w_note_idx = 4'd3;
      8'h21: w_note_idx = 4'd4;
      8'h2A: w_note_idx = 4'd5;
      8'h34: w_note_idx = 4'd6;
      8'h32: w_note_idx = 4'd7;
      8'h33: w_note_idx = 4'd8;
      8'h31: w_note_idx = 4'd9;
      8'h3B: w_note_idx = 4'd10;
      8'h3A: w_note_idx = 4'd11;
      default: w_is_note = 1'b0;
    endcase
    case (bus.iScanCode)
      8'h1D: w_ctl = 4'b1000;
      8'h15: w_ctl = 4'b0100;
      8'h4D: w_ctl = 4'b0010;
      8'h44: w_ctl = 4'b0001;
      default: w_ctl = 4'b0000;
    endcase
    case (bus.iScanCode)
      8'h16: begin w_is_sel = 1'b1; w_sel = 3'd0; end
      8'h1E: begin w_is_sel = 1'b1; w_sel = 3'd1; end
      8'h26: begin w_is_sel = 1'b1; w_sel = 3'd2; end
      8'h25: begin w_is_sel = 1'b1; w_sel = 3'd3; end
      default: begin w_is_sel = 1'b0; w_sel = 3'd0; end
    endcase
  end

`ifdef SYNTH_KEY_TYPEMATIC_FILTER_EN
  logic [3:0] r_held;

  always_ff @(posedge iClock) begin
    if (iReset)                 r_held <= 4'b0000;
    else if (w_make)            r_held <= r_held | w_ctl;
    else if (w_brk)             r_held <= r_held & ~w_ctl;
  end

  wire w_note_repeat = r_note_in && (r_note == w_note_idx);
  wire [3:0] w_pulse_nxt = w_ctl & ~r_held;
`else
  wire w_note_repeat = 1'b0;
  wire [3:0] w_pulse_nxt = w_ctl;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_note    <= 4'd0;
      r_note_in <= 1'b0;
      r_pulse   <= 4'b0000;
      r_sel     <= 3'd0;
    end else begin
      r_pulse <= 4'b0000;
      if (w_make) begin
        if (w_is_note && !w_note_repeat) begin
          r_note    <= w_note_idx;
          r_note_in <= 1'b1;
        end
        if (w_is_sel) r_sel <= w_sel;
        r_pulse <= w_pulse_nxt;
      end
      // Only releasing the most recent note silences the output.
      if (w_brk && w_is_note && (w_note_idx == r_note)) r_note_in <= 1'b0;
    end
  end

  assign bus.oNote             = r_note;
  assign bus.oNoteIn           = r_note_in;
  assign bus.oOctavePlusPlus   = r_pulse[3];
  assign bus.oOctaveMinusMinus = r_pulse[2];
  assign bus.oADSRPlusPlus     = r_pulse[1];
  assign bus.oADSRMinusMinus   = r_pulse[0];
  assign bus.oADSRSelector     = r_sel;
endmodule

// File: tb/tb_synth_key_decoder.sv
// Directed-vector bench for synth_key_decoder; expectations follow SYNTH_KEY_TYPEMATIC_FILTER_EN.
module tb_synth_key_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  synth_key_if bus ();
  synth_key_decoder dut (.iClock(clk), .iReset(rst), .bus(bus));

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] code;
    logic [3:0] n;
    logic       nin;
    logic [3:0] p;
    logic [2:0] sel;
  } vec_t;

  vec_t vecs[$];

`ifdef SYNTH_KEY_TYPEMATIC_FILTER_EN
  localparam logic [3:0] REP_P   = 4'b0000;
  localparam int         OPP_EXP = 2;
`else
  localparam logic [3:0] REP_P   = 4'b1000;
  localparam int         OPP_EXP = 3;
`endif

  task automatic add(input logic r, input logic v, input logic [7:0] c, input logic [3:0] n,
                     input logic nin, input logic [3:0] p, input logic [2:0] s);
    vec_t t;
    t.rst = r; t.v = v; t.code = c; t.n = n; t.nin = nin; t.p = p; t.sel = s;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {bus.oOctavePlusPlus, bus.oOctaveMinusMinus, bus.oADSRPlusPlus, bus.oADSRMinusMinus};
  endfunction

  task automatic step(input logic r, input logic v, input logic [7:0] c);
    @(negedge clk);
    rst = r; bus.iScanValid = v; bus.iScanCode = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int opp_cnt;
    int app_at;
    int amm_at;
    bus.iScanValid = 1'b0;
    bus.iScanCode  = 8'h00;

    add(1,0,8'h00, 0,0,4'h0,0);
    add(0,1,8'h1A, 0,1,4'h0,0);
    add(0,1,8'hF0, 0,1,4'h0,0);
    add(0,1,8'h1A, 0,0,4'h0,0);
    add(0,1,8'h22, 2,1,4'h0,0);
    add(0,1,8'h3A,11,1,4'h0,0);
    add(0,1,8'hF0,11,1,4'h0,0);
    add(0,1,8'h22,11,1,4'h0,0);
    add(0,1,8'hF0,11,1,4'h0,0);
    add(0,1,8'h3A,11,0,4'h0,0);
    add(0,1,8'h1D,11,0,4'h8,0);
    add(0,1,8'h1D,11,0,REP_P,0);
    add(0,1,8'hF0,11,0,4'h0,0);
    add(0,1,8'h1D,11,0,4'h0,0);
    add(0,1,8'h1D,11,0,4'h8,0);
    add(0,0,8'h1D,11,0,4'h0,0);
    add(0,1,8'hE0,11,0,4'h0,0);
    add(0,1,8'h1A,11,0,4'h0,0);
    add(0,1,8'h1A, 0,1,4'h0,0);
    add(0,1,8'hF0, 0,1,4'h0,0);
    add(0,1,8'hF0, 0,1,4'h0,0);
    add(0,1,8'h1A, 0,0,4'h0,0);
    add(0,1,8'hF0, 0,0,4'h0,0);
    add(0,1,8'hE0, 0,0,4'h0,0);
    add(0,1,8'h21, 4,1,4'h0,0);
    add(0,1,8'hE0, 4,1,4'h0,0);
    add(0,1,8'hF0, 4,1,4'h0,0);
    add(0,1,8'hE0, 4,1,4'h0,0);
    add(0,1,8'h22, 2,1,4'h0,0);
    add(0,1,8'hE0, 2,1,4'h0,0);
    add(0,1,8'hE0, 2,1,4'h0,0);
    add(0,1,8'h3B,10,1,4'h0,0);
    add(0,1,8'h26,10,1,4'h0,2);
    add(0,1,8'hF0,10,1,4'h0,2);
    add(1,0,8'h00, 0,0,4'h0,0);
    add(0,1,8'h16, 0,0,4'h0,0);
    add(0,1,8'h1A, 0,1,4'h0,0);
    add(0,1,8'hF0, 0,1,4'h0,0);
    add(1,0,8'h00, 0,0,4'h0,0);
    add(0,1,8'h1A, 0,1,4'h0,0);
    add(1,1,8'h1A, 0,0,4'h0,0);
    add(0,1,8'h1D, 0,0,4'h8,0);
    add(1,0,8'h00, 0,0,4'h0,0);
    add(0,1,8'h1D, 0,0,4'h8,0);
    add(0,1,8'hF0, 0,0,4'h0,0);
    add(0,1,8'h1D, 0,0,4'h0,0);
    add(0,1,8'h4D, 0,0,4'h2,0);
    add(0,1,8'h44, 0,0,4'h1,0);
    add(0,1,8'h15, 0,0,4'h4,0);
    add(0,1,8'h55, 0,0,4'h0,0);
    add(0,1,8'hF0, 0,0,4'h0,0);
    add(0,1,8'h55, 0,0,4'h0,0);
    add(0,1,8'h1E, 0,0,4'h0,1);
    add(0,1,8'h25, 0,0,4'h0,3);
    add(0,1,8'h3B,10,1,4'h0,3);
    add(0,1,8'h3B,10,1,4'h0,3);
    add(0,1,8'hF0,10,1,4'h0,3);
    add(0,1,8'h3B,10,0,4'h0,3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].code);
      chk($sformatf("vec%0d code=%h", i, vecs[i].code),
          {20'd0, bus.oNote, bus.oNoteIn, pulses(), bus.oADSRSelector},
          {20'd0, vecs[i].n, vecs[i].nin, vecs[i].p, vecs[i].sel});
    end

    // Octave++ pulse count across a typematic repeat sequence.
    step(1, 0, 8'h00);
    opp_cnt = 0;
    foreach (vecs[k]) begin end
    begin
      logic [7:0] seq [0:6];
      seq[0] = 8'h1D; seq[1] = 8'h1D; seq[2] = 8'hF0; seq[3] = 8'h1D;
      seq[4] = 8'h1D; seq[5] = 8'h00; seq[6] = 8'h00;
      for (int j = 0; j < 7; j++) begin
        step(0, (j < 5), seq[j]);
        if (bus.oOctavePlusPlus === 1'b1) opp_cnt++;
        chk($sformatf("onehot_opp%0d", j), {31'd0, $onehot0(pulses())}, 32'd1);
      end
    end
    chk("opp_count", opp_cnt, OPP_EXP);

    // ADSR++ then ADSR-- on adjacent cycles.
    app_at = -1;
    amm_at = -1;
    begin
      logic [7:0] seq2 [0:3];
      seq2[0] = 8'h4D; seq2[1] = 8'h44; seq2[2] = 8'h00; seq2[3] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        step(0, (j < 2), seq2[j]);
        if (bus.oADSRPlusPlus === 1'b1) app_at = j;
        if (bus.oADSRMinusMinus === 1'b1) amm_at = j;
        chk($sformatf("onehot_adsr%0d", j), {31'd0, $onehot0(pulses())}, 32'd1);
      end
    end
    chk("adsr_pp_cycle", app_at, 0);
    chk("adsr_mm_cycle", amm_at, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
